// File: rtl/audio_sched_pkg.sv
// audio_sched_pkg: CPU IO address map, status bit layout and scheduler state type
// shared by audio_sched and its testbench.
package audio_sched_pkg;

    localparam logic [1:0] ADDR_LEFT       = 2'd0;
    localparam logic [1:0] ADDR_RIGHT_PUSH = 2'd1;
    localparam logic [1:0] ADDR_CLEAR      = 2'd2;

    localparam int ST_FULL  = 8;
    localparam int ST_EMPTY = 9;
    localparam int ST_UFLOW = 10;
    localparam int ST_OFLOW = 11;
    localparam int ST_RUN   = 12;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/audio_sched_sample_fifo.sv
// sample_fifo: synchronous 32-bit x DEPTH FIFO holding {right, left} pairs.
// Pushes when full and pops when empty are ignored; head is the oldest entry.
module sample_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetq,
    input  logic                     push,
    input  logic [31:0]              push_data,
    input  logic                     pop,
    output logic [31:0]              head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/audio_sched.sv
// audio_sched: CPU-fed stereo sample FIFO drained by a DDA rate generator into the HDMI audio port.
// Build option: define AUDIO_SCHED_UFLOW_CNT_EN to build the saturating underrun counter.
//   state  | meaning
//   S_IDLE | waiting for the first start (VSYNC); DDA held at 0, no ticks
//   S_RUN  | one tick per audio period, until reset
module audio_sched
    import audio_sched_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 74250000,
    parameter int unsigned RATE_HZ = 48000,
    parameter int unsigned DEPTH   = 16
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        start,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] status,
    output logic [7:0]  uflow_cnt,
    output logic        audio_w,
    output logic [31:0] audio
);
    localparam int          LW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] STEP_UP = 32'(RATE_HZ);
    localparam logic [31:0] STEP_DN = 32'(RATE_HZ) - 32'(CLK_HZ);

    run_state_e    state_q, state_d;
    logic [31:0]   d_q, d_d;
    logic [15:0]   left_q, left_d;
    logic [31:0]   audio_q, audio_d;
    logic          audio_w_q, audio_w_d;
    logic          uflow_q, uflow_d;
    logic          oflow_q, oflow_d;

    logic          running, tick, underrun;
    logic          wr_left, wr_push, wr_clear, push, pop;
    logic          fifo_full, fifo_empty;
    logic [31:0]   fifo_head;
    logic [LW-1:0] fifo_level;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    assign running  = (state_q == S_RUN);
    assign tick     = running & ~d_q[31];
    assign wr_left  = cpu_wr & (cpu_addr == ADDR_LEFT);
    assign wr_push  = cpu_wr & (cpu_addr == ADDR_RIGHT_PUSH);
    assign wr_clear = cpu_wr & (cpu_addr == ADDR_CLEAR);
    // Full is judged on the registered level, so a same-cycle pop never rescues a push.
    assign push     = wr_push & ~fifo_full;
    assign pop      = tick & ~fifo_empty;
    assign underrun = tick & fifo_empty;

    always_comb begin
        d_d       = '0;
        left_d    = left_q;
        audio_d   = audio_q;
        audio_w_d = tick;
        if (running) d_d = d_q + (d_q[31] ? STEP_UP : STEP_DN);
        if (wr_left) left_d = cpu_din;
        if (pop)     audio_d = fifo_head;
        uflow_d   = (uflow_q & ~wr_clear) | underrun;
        oflow_d   = (oflow_q & ~wr_clear) | (wr_push & fifo_full);
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q   <= S_IDLE;
            d_q       <= '0;
            left_q    <= '0;
            audio_q   <= '0;
            audio_w_q <= 1'b0;
            uflow_q   <= 1'b0;
            oflow_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            left_q    <= left_d;
            audio_q   <= audio_d;
            audio_w_q <= audio_w_d;
            uflow_q   <= uflow_d;
            oflow_q   <= oflow_d;
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetq    (resetq),
        .push      (push),
        .push_data ({cpu_din, left_q}),
        .pop       (pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef AUDIO_SCHED_UFLOW_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;
    logic [7:0] ucnt_base;

    always_comb begin
        ucnt_base = wr_clear ? 8'd0 : ucnt_q;
        ucnt_d    = ucnt_base;
        if (underrun && ucnt_base != 8'hFF) ucnt_d = ucnt_base + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetq) ucnt_q <= '0;
        else         ucnt_q <= ucnt_d;
    end

    assign uflow_cnt = ucnt_q;
`else
    assign uflow_cnt = 8'd0;
`endif

    always_comb begin
        status           = '0;
        status[7:0]      = 8'(fifo_level);
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_UFLOW] = uflow_q;
        status[ST_OFLOW] = oflow_q;
        status[ST_RUN]   = running;
    end

    assign audio_w = audio_w_q;
    assign audio   = audio_q;

endmodule
